// File: rtl/reset_sequencer.sv
// Power-on reset sequencer: releases peripheral, memory and core resets in
// order once the clock source is locked, with a bounded memory-init phase.
module reset_sequencer #(
    parameter int HOLD_CYCLES  = 16,
    parameter int GAP_CYCLES   = 4,
    parameter int INIT_TIMEOUT = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic locked,
    input  logic soft_rst_req,
    input  logic mem_init_done,
    output logic rst_periph,
    output logic rst_mem,
    output logic rst_core,
    output logic mem_init_start,
    output logic init_timeout,
    output logic seq_done
);

    localparam int MAX_AB = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int MAX_C  = (MAX_AB > INIT_TIMEOUT) ? MAX_AB : INIT_TIMEOUT;
    localparam int CW     = (MAX_C > 1) ? $clog2(MAX_C) : 1;

    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);
    localparam logic [CW-1:0] INIT_LAST = CW'(INIT_TIMEOUT - 1);

    typedef enum logic [2:0] {
        HOLD,
        PERIPH,
        MEM,
        INIT,
        CORE,
        RUN
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nx;
    logic          timeout_hit;

    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt + CW'(1);
        timeout_hit = 1'b0;
        if (!locked || soft_rst_req) begin
            state_nx = HOLD;
        end else begin
            case (state)
                HOLD:    if (cnt == HOLD_LAST) state_nx = PERIPH;
                PERIPH:  if (cnt == GAP_LAST) state_nx = MEM;
                MEM:     if (cnt == GAP_LAST) state_nx = INIT;
                INIT: begin
                    // Completion wins over a timeout landing on the same edge.
                    if (mem_init_done) begin
                        state_nx = CORE;
                    end else if (cnt == INIT_LAST) begin
                        state_nx    = CORE;
                        timeout_hit = 1'b1;
                    end
                end
                CORE:    if (cnt == GAP_LAST) state_nx = RUN;
                RUN:     cnt_nx = cnt;
                default: state_nx = HOLD;
            endcase
        end
        if (state_nx != state || !locked || soft_rst_req) begin
            cnt_nx = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= HOLD;
            cnt            <= '0;
            rst_periph     <= 1'b1;
            rst_mem        <= 1'b1;
            rst_core       <= 1'b1;
            mem_init_start <= 1'b0;
            init_timeout   <= 1'b0;
            seq_done       <= 1'b0;
        end else begin
            state          <= state_nx;
            cnt            <= cnt_nx;
            rst_periph     <= (state_nx == HOLD);
            rst_mem        <= (state_nx == HOLD) || (state_nx == PERIPH);
            rst_core       <= (state_nx != CORE) && (state_nx != RUN);
            mem_init_start <= (state_nx == INIT) && (state != INIT);
            seq_done       <= (state_nx == RUN);
            if (timeout_hit) begin
                init_timeout <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: edge-numbered vectors with
// hand-computed release points for each scenario.
module tb_reset_sequencer;

    logic clk = 1'b0;
    logic rst;
    logic locked;
    logic soft_rst_req;
    logic mem_init_done;
    logic rst_periph;
    logic rst_mem;
    logic rst_core;
    logic mem_init_start;
    logic init_timeout;
    logic seq_done;

    int n_vec = 0;
    int n_bad = 0;
    int edge_n = 0;
    int base = 0;

    always #5 clk = ~clk;

    reset_sequencer dut (
        .clk           (clk),
        .rst           (rst),
        .locked        (locked),
        .soft_rst_req  (soft_rst_req),
        .mem_init_done (mem_init_done),
        .rst_periph    (rst_periph),
        .rst_mem       (rst_mem),
        .rst_core      (rst_core),
        .mem_init_start(mem_init_start),
        .init_timeout  (init_timeout),
        .seq_done      (seq_done)
    );

    task automatic check(input string tag, input logic got, input logic exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @E%0d: got %b expected %b", tag, edge_n - base, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        edge_n++;
        #1;
    endtask

    task automatic to_rel(input int k);
        while (edge_n < base + k) tick();
    endtask

    // Reset sampled at relative edge E0; rst low from E1 onward.
    task automatic do_reset();
        rst = 1'b1;
        tick();
        base = edge_n;
        rst = 1'b0;
    endtask

    task automatic check_all_reset(input string tag);
        check({tag, "_periph"}, rst_periph, 1'b1);
        check({tag, "_mem"}, rst_mem, 1'b1);
        check({tag, "_core"}, rst_core, 1'b1);
        check({tag, "_start"}, mem_init_start, 1'b0);
        check({tag, "_done"}, seq_done, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        locked = 1'b1;
        soft_rst_req = 1'b0;
        mem_init_done = 1'b0;

        // Nominal sequence
        do_reset();
        check_all_reset("rst");
        check("rst_tmo", init_timeout, 1'b0);
        to_rel(15); check("p15", rst_periph, 1'b1);
        to_rel(16); check("p16", rst_periph, 1'b0);
        check("m16", rst_mem, 1'b1);
        to_rel(19); check("m19", rst_mem, 1'b1);
        to_rel(20); check("m20", rst_mem, 1'b0);
        to_rel(23); check("s23", mem_init_start, 1'b0);
        to_rel(24); check("s24", mem_init_start, 1'b1);
        check("c24", rst_core, 1'b1);
        to_rel(25); check("s25", mem_init_start, 1'b0);
        to_rel(29); check("c29", rst_core, 1'b1);
        mem_init_done = 1'b1;
        to_rel(30); check("c30", rst_core, 1'b0);
        check("t30", init_timeout, 1'b0);
        check("s30", mem_init_start, 1'b0);
        to_rel(33); check("d33", seq_done, 1'b0);
        to_rel(34); check("d34", seq_done, 1'b1);

        // Soft reset from RUN; mem_init_done stays high and must be ignored
        to_rel(40);
        soft_rst_req = 1'b1;
        to_rel(41); check_all_reset("soft");
        soft_rst_req = 1'b0;
        to_rel(56); check("sp56", rst_periph, 1'b1);
        to_rel(57); check("sp57", rst_periph, 1'b0);
        to_rel(60); check("sm60", rst_mem, 1'b1);
        to_rel(61); check("sm61", rst_mem, 1'b0);
        check("sc61", rst_core, 1'b1);
        to_rel(64); check("ss64", mem_init_start, 1'b0);
        check("sc64", rst_core, 1'b1);
        to_rel(65); check("ss65", mem_init_start, 1'b1);
        check("sc65", rst_core, 1'b1);
        to_rel(66); check("ss66", mem_init_start, 1'b0);
        check("sc66", rst_core, 1'b0);
        to_rel(69); check("sd69", seq_done, 1'b0);
        to_rel(70); check("sd70", seq_done, 1'b1);
        mem_init_done = 1'b0;

        // Soft reset held high pins the block in HOLD
        soft_rst_req = 1'b1;
        to_rel(95); check_all_reset("shold");
        soft_rst_req = 1'b0;
        to_rel(110); check("shp", rst_periph, 1'b1);
        to_rel(111); check("shr", rst_periph, 1'b0);

        // Single-cycle lock loss in HOLD, then loss during PERIPH
        do_reset();
        to_rel(9);
        locked = 1'b0;
        to_rel(10); check("l10", rst_periph, 1'b1);
        locked = 1'b1;
        to_rel(25); check("l25", rst_periph, 1'b1);
        to_rel(26); check("l26", rst_periph, 1'b0);
        to_rel(27);
        locked = 1'b0;
        to_rel(28); check("lp_periph", rst_periph, 1'b1);
        check("lp_mem", rst_mem, 1'b1);
        locked = 1'b1;

        // Timeout, sticky across soft reset, cleared by rst
        do_reset();
        to_rel(1047); check("tc1047", rst_core, 1'b1);
        check("tt1047", init_timeout, 1'b0);
        to_rel(1048); check("tc1048", rst_core, 1'b0);
        check("tt1048", init_timeout, 1'b1);
        to_rel(1051); check("td1051", seq_done, 1'b0);
        to_rel(1052); check("td1052", seq_done, 1'b1);
        soft_rst_req = 1'b1;
        to_rel(1053); check("tsoft", init_timeout, 1'b1);
        check("tsoftc", rst_core, 1'b1);
        soft_rst_req = 1'b0;
        do_reset();
        check("tclr", init_timeout, 1'b0);

        // Completion on the timeout edge beats the timeout
        to_rel(1047);
        mem_init_done = 1'b1;
        to_rel(1048); check("wc1048", rst_core, 1'b0);
        check("wt1048", init_timeout, 1'b0);
        mem_init_done = 1'b0;

        // rst during INIT with mem_init_done on the same edge
        do_reset();
        to_rel(29);
        rst = 1'b1;
        mem_init_done = 1'b1;
        tick();
        check_all_reset("ri");
        check("ri_tmo", init_timeout, 1'b0);
        rst = 1'b0;
        mem_init_done = 1'b0;
        tick(); tick(); tick(); tick(); tick();
        check("ri_core", rst_core, 1'b1);
        check("ri_periph", rst_periph, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 Parameter HOLD_CYCLES, default 16: cycles of stable lock required before the first reset release (>=1).
REQ-002 Parameter GAP_CYCLES, default 4: spacing in cycles between successive domain releases (>=1).
REQ-003 Parameter INIT_TIMEOUT, default 1024: maximum cycles spent waiting for mem_init_done (>=1).
REQ-004 clk  input  1  single system clock; all logic on posedge clk only.
REQ-005 rst  input  1  synchronous active-high reset, already synchronized to clk.
REQ-006 locked  input  1  clock-source stable indication, synchronous to clk.
REQ-007 soft_rst_req  input  1  request to rerun the full sequence, level-sampled each cycle.
REQ-008 mem_init_done  input  1  memory-init completion, sampled only in state INIT.
REQ-009 rst_periph  output  1  active-high reset for the peripheral domain, registered.
REQ-010 rst_mem  output  1  active-high reset for the memory domain, registered.
REQ-011 rst_core  output  1  active-high reset for the CPU core, registered.
REQ-012 mem_init_start  output  1  single-cycle pulse requesting memory initialization, registered.
REQ-013 init_timeout  output  1  sticky flag: memory init timed out.
REQ-014 seq_done  output  1  high while the sequence has completed (state RUN).

Function
REQ-015 FSM states HOLD, PERIPH, MEM, INIT, CORE, RUN; one shared counter sized to hold max(HOLD_CYCLES, GAP_CYCLES, INIT_TIMEOUT)-1; the counter is zeroed on every state change.
REQ-016 Priority per edge: rst > (locked==0) > soft_rst_req > normal sequencing.
REQ-017 HOLD: counter increments while locked=1; at the edge where the counter value is HOLD_CYCLES-1, go to PERIPH and drive rst_periph=0.
REQ-018 PERIPH: at counter==GAP_CYCLES-1, go to MEM and drive rst_mem=0.
REQ-019 MEM: at counter==GAP_CYCLES-1, go to INIT and drive mem_init_start=1 for exactly the first INIT cycle.
REQ-020 INIT: mem_init_done=1 sampled at an edge -> go to CORE and drive rst_core=0; otherwise the counter increments.
REQ-021 INIT timeout: at counter==INIT_TIMEOUT-1 with mem_init_done=0, go to CORE, drive rst_core=0, and set init_timeout=1.
REQ-022 If mem_init_done=1 on the timeout edge, completion wins and init_timeout is not set.
REQ-023 CORE: at counter==GAP_CYCLES-1, go to RUN and drive seq_done=1; RUN is held indefinitely.
REQ-024 Deassert order is always periph, then mem, then core; no output deasserts out of order.
REQ-025 locked=0 in any state: next edge go to HOLD with counter 0, all rst_* = 1, seq_done=0, mem_init_start=0.
REQ-026 soft_rst_req=1 in any state: same action as REQ-025; held high, it keeps the block in HOLD with counter 0.
REQ-027 Re-entry to HOLD does not clear init_timeout; only rst clears it.
REQ-028 mem_init_done is ignored outside INIT; mem_init_start never pulses more than once per pass through the sequence.

Reset
REQ-029 rst=1 at an edge: state HOLD, counter 0, rst_periph=rst_mem=rst_core=1, mem_init_start=0, init_timeout=0, seq_done=0.
REQ-030 rst=1 mid-sequence, including during INIT, aborts the sequence immediately and applies REQ-029.

Verification
REQ-031 Defaults, locked=1, rst low from edge E1, mem_init_done=1 at E30 -> rst_periph falls at E16, rst_mem at E20, mem_init_start high only between E24 and E25, rst_core falls at E30, seq_done rises at E34.
REQ-032 Defaults, mem_init_done held 0 -> rst_core falls and init_timeout rises at E1048, seq_done rises at E1052, init_timeout stays 1 afterwards.
REQ-033 locked drops for 1 cycle at E10, then recovers -> HOLD restarts and rst_periph falls 16 edges after locked returns high.
REQ-034 soft_rst_req pulse in RUN -> next edge all rst_*=1 and seq_done=0; the full sequence replays with the same spacing and a new single mem_init_start pulse.
REQ-035 mem_init_done=1 exactly at the timeout edge -> rst_core falls and init_timeout stays 0.
REQ-036 rst=1 in INIT with mem_init_done=1 on the same edge -> reset wins, all rst_*=1, no transition to CORE.
